// File: rtl/load_store_unit.sv
// load_store_unit
//
// Memory stage of the vanilla core. Takes the execute-stage effective address,
// store operand and access type, and issues one word-aligned request at a time
// to the data memory port, using byte masks and lane replication. Load
// responses are aligned, sign- or zero-extended and presented for writeback.
// Misaligned or illegal-size accesses raise a one-cycle flag and issue nothing.
//
// Ports:
//   clk_i, reset_i        core clock, synchronous active-high reset
//   v_i / ready_o         access handshake from the execute stage
//   op_i                  01 load, 10 store, 00/11 dropped
//   size_i, unsigned_i    0 byte, 1 half, 2 word, 3 illegal; load zero-extend
//   addr_i, store_data_i  effective address, rs2 value
//   rd_i                  load destination register
//   mem_v_o ... mem_mask_o  registered memory request, held until mem_ready_i
//   mem_v_i, mem_rdata_i  load response
//   wb_v_o, wb_rd_o, wb_data_o  writeback pulse, register, extended data
//   misaligned_o          one-cycle pulse on misaligned/illegal access
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a new access
// ST_REQ   | request presented on mem_*, waiting for mem_ready_i
// ST_WAIT  | load request accepted, waiting for mem_v_i

module load_store_unit #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [1:0]                  op_i,
    input  logic [1:0]                  size_i,
    input  logic                        unsigned_i,
    input  logic [data_width_p-1:0]     addr_i,
    input  logic [data_width_p-1:0]     store_data_i,
    input  logic [reg_addr_width_p-1:0] rd_i,

    output logic                        mem_v_o,
    input  logic                        mem_ready_i,
    output logic                        mem_we_o,
    output logic [data_width_p-1:0]     mem_addr_o,
    output logic [data_width_p-1:0]     mem_wdata_o,
    output logic [3:0]                  mem_mask_o,

    input  logic                        mem_v_i,
    input  logic [data_width_p-1:0]     mem_rdata_i,

    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_o,
    output logic [data_width_p-1:0]     wb_data_o,
    output logic                        misaligned_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                      state_r;
    logic                        is_load_r;
    logic [1:0]                  size_r;
    logic                        unsigned_r;
    logic [1:0]                  off_r;
    logic [reg_addr_width_p-1:0] rd_r;

    logic                        is_load_c;
    logic                        is_store_c;
    logic                        misalign_c;
    logic [3:0]                  mask_c;
    logic [data_width_p-1:0]     wdata_c;
    logic [7:0]                  byte_sel_c;
    logic [15:0]                 half_sel_c;
    logic [data_width_p-1:0]     load_data_c;

    assign ready_o = (state_r == ST_IDLE);
    assign mem_v_o = (state_r == ST_REQ);

    assign is_load_c  = (op_i == 2'b01);
    assign is_store_c = (op_i == 2'b10);

    assign misalign_c = (size_i == 2'd3)
                      || ((size_i == 2'd1) && addr_i[0])
                      || ((size_i == 2'd2) && (addr_i[1:0] != 2'b00));

    always_comb begin
        mask_c  = 4'hF;
        wdata_c = store_data_i;
        case (size_i)
            2'd0: begin
                mask_c  = 4'b0001 << addr_i[1:0];
                wdata_c = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                mask_c  = 4'b0011 << addr_i[1:0];
                wdata_c = {2{store_data_i[15:0]}};
            end
            default: begin
                mask_c  = 4'hF;
                wdata_c = store_data_i;
            end
        endcase
        if (is_load_c) begin
            wdata_c = '0;
        end
    end

    // Lane selects equal the low bits of rdata >> (8*offset); halves are
    // always 2-byte aligned here because misaligned halves never issue.
    assign byte_sel_c = mem_rdata_i[{off_r, 3'b000} +: 8];
    assign half_sel_c = mem_rdata_i[{off_r[1], 4'b0000} +: 16];

    always_comb begin
        case (size_r)
            2'd0:    load_data_c = {{24{byte_sel_c[7] & ~unsigned_r}}, byte_sel_c};
            2'd1:    load_data_c = {{16{half_sel_c[15] & ~unsigned_r}}, half_sel_c};
            default: load_data_c = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= ST_IDLE;
            is_load_r    <= 1'b0;
            size_r       <= 2'd0;
            unsigned_r   <= 1'b0;
            off_r        <= 2'd0;
            rd_r         <= '0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_mask_o   <= 4'h0;
            wb_v_o       <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            misaligned_o <= 1'b0;
        end else begin
            wb_v_o       <= 1'b0;
            misaligned_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (v_i && (is_load_c || is_store_c)) begin
                        if (misalign_c) begin
                            misaligned_o <= 1'b1;
                        end else begin
                            is_load_r   <= is_load_c;
                            size_r      <= size_i;
                            unsigned_r  <= unsigned_i;
                            off_r       <= addr_i[1:0];
                            rd_r        <= rd_i;
                            mem_we_o    <= is_store_c;
                            mem_addr_o  <= {addr_i[data_width_p-1:2], 2'b00};
                            mem_wdata_o <= wdata_c;
                            mem_mask_o  <= mask_c;
                            state_r     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready_i) begin
                        state_r <= is_load_r ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_v_i) begin
                        wb_data_o <= load_data_c;
                        wb_rd_o   <= rd_r;
                        wb_v_o    <= (rd_r != '0);
                        state_r   <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        mem_v_o;
    logic        mem_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_mask_o;
    logic        mem_v_i;
    logic [31:0] mem_rdata_i;
    logic        wb_v_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;

    load_store_unit dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .v_i(v_i), .ready_o(ready_o), .op_i(op_i), .size_i(size_i),
        .unsigned_i(unsigned_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .rd_i(rd_i),
        .mem_v_o(mem_v_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o),
        .mem_v_i(mem_v_i), .mem_rdata_i(mem_rdata_i),
        .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_v_o && mem_ready_i) hs_count++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_access(input logic [1:0] op, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] data, input logic [4:0] rd);
        v_i = 1'b1; op_i = op; size_i = size; unsigned_i = uns;
        addr_i = addr; store_data_i = data; rd_i = rd;
    endtask

    task automatic idle_inputs();
        v_i = 1'b0; op_i = 2'b00; size_i = 2'd0; unsigned_i = 1'b0;
        addr_i = '0; store_data_i = '0; rd_i = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) step();
        reset_i = 1'b0;
        step();
        checks++;
        if (ready_o !== 1'b1 || mem_v_o !== 1'b0 || wb_v_o !== 1'b0 || misaligned_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b mem_v=%b wb_v=%b mis=%b, want 1 0 0 0",
                     ready_o, mem_v_o, wb_v_o, misaligned_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_mask_o !== 4'h0 ||
            wb_rd_o !== 5'h0 || wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h mask=%h rd=%h wb=%h, want all 0",
                     mem_addr_o, mem_wdata_o, mem_mask_o, wb_rd_o, wb_data_o);
        end
    endtask

    task automatic test_store_word();
        drive_access(2'b10, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 5'd0);
        mem_ready_i = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (mem_v_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_1004 ||
            mem_mask_o !== 4'hF || mem_wdata_o !== 32'hDEAD_BEEF || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_req: v=%b we=%b addr=%h mask=%h wdata=%h ready=%b, want 1 1 00001004 f deadbeef 0",
                     mem_v_o, mem_we_o, mem_addr_o, mem_mask_o, mem_wdata_o, ready_o);
        end
        step();
        mem_ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || mem_v_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_done: ready=%b mem_v=%b, want 1 0", ready_o, mem_v_o);
        end
    endtask

    task automatic test_store_byte_stall();
        int hs_start;
        hs_start = hs_count;
        mem_ready_i = 1'b0;
        drive_access(2'b10, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd0);
        step();
        idle_inputs();
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (mem_v_o !== 1'b1 || mem_mask_o !== 4'b1000 || mem_wdata_o !== 32'hA5A5_A5A5 ||
                mem_addr_o !== 32'h0000_1000 || mem_we_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL sb_stall_c%0d: v=%b mask=%b wdata=%h addr=%h we=%b ready=%b, want 1 1000 a5a5a5a5 00001000 1 0",
                         c, mem_v_o, mem_mask_o, mem_wdata_o, mem_addr_o, mem_we_o, ready_o);
            end
            if (c == 3) mem_ready_i = 1'b1;
            step();
        end
        mem_ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || mem_v_o !== 1'b0 || (hs_count - hs_start) !== 1) begin
            errors++;
            $display("FAIL sb_done: ready=%b mem_v=%b handshakes=%0d, want 1 0 1",
                     ready_o, mem_v_o, hs_count - hs_start);
        end
    endtask

    task automatic do_load(input string name, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [4:0] rd,
                           input logic [3:0] exp_mask, input logic [31:0] rdata,
                           input logic exp_wb, input logic [31:0] exp_data);
        drive_access(2'b01, size, uns, addr, 32'hFFFF_FFFF, rd);
        step();
        idle_inputs();
        checks++;
        if (mem_v_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== {addr[31:2], 2'b00} ||
            mem_mask_o !== exp_mask || mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL %s_req: v=%b we=%b addr=%h mask=%b wdata=%h, want 1 0 %h %b 0",
                     name, mem_v_o, mem_we_o, mem_addr_o, mem_mask_o, mem_wdata_o,
                     {addr[31:2], 2'b00}, exp_mask);
        end
        // a response in the handshake cycle must be ignored
        mem_ready_i = 1'b1;
        mem_v_i = 1'b1;
        mem_rdata_i = 32'h5A5A_5A5A;
        step();
        mem_ready_i = 1'b0;
        mem_v_i = 1'b0;
        checks++;
        if (wb_v_o !== 1'b0 || ready_o !== 1'b0 || mem_v_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: wb_v=%b ready=%b mem_v=%b, want 0 0 0",
                     name, wb_v_o, ready_o, mem_v_o);
        end
        step();
        mem_v_i = 1'b1;
        mem_rdata_i = rdata;
        step();
        mem_v_i = 1'b0;
        checks++;
        if (wb_v_o !== exp_wb || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_wb_v: wb_v=%b ready=%b, want %b 1", name, wb_v_o, ready_o, exp_wb);
        end
        if (exp_wb) begin
            checks++;
            if (wb_rd_o !== rd || wb_data_o !== exp_data) begin
                errors++;
                $display("FAIL %s_wb_data: rd=%0d data=%h, want %0d %h",
                         name, wb_rd_o, wb_data_o, rd, exp_data);
            end
        end
        step();
        checks++;
        if (wb_v_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_wb_pulse: wb_v=%b, want 0", name, wb_v_o);
        end
    endtask

    task automatic test_loads();
        do_load("lb",   2'd0, 1'b0, 32'h0000_2002, 5'd7, 4'b0100, 32'h12F4_3456, 1'b1, 32'hFFFF_FFF4);
        do_load("lbu",  2'd0, 1'b1, 32'h0000_2002, 5'd7, 4'b0100, 32'h12F4_3456, 1'b1, 32'h0000_00F4);
        do_load("lb1",  2'd0, 1'b0, 32'h0000_2001, 5'd9, 4'b0010, 32'h12F4_3456, 1'b1, 32'h0000_0034);
        do_load("lh",   2'd1, 1'b0, 32'h0000_2002, 5'd4, 4'b1100, 32'h8765_4321, 1'b1, 32'hFFFF_8765);
        do_load("lhu",  2'd1, 1'b1, 32'h0000_2002, 5'd4, 4'b1100, 32'h8765_4321, 1'b1, 32'h0000_8765);
        do_load("lw",   2'd2, 1'b0, 32'h0000_3008, 5'd31, 4'hF,   32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D);
        do_load("lwr0", 2'd2, 1'b0, 32'h0000_3000, 5'd0, 4'hF,    32'hCAFE_F00D, 1'b0, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [1:0]  ops   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0]  sizes [4] = '{2'd1,  2'd2,  2'd3,  2'd1};
        logic [31:0] addrs [4] = '{32'h2001, 32'h1002, 32'h2000, 32'h1003};
        for (int i = 0; i < 4; i++) begin
            drive_access(ops[i], sizes[i], 1'b0, addrs[i], 32'h1234_5678, 5'd3);
            step();
            idle_inputs();
            checks++;
            if (misaligned_o !== 1'b1 || mem_v_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL misaligned_%0d: mis=%b mem_v=%b ready=%b, want 1 0 1",
                         i, misaligned_o, mem_v_o, ready_o);
            end
            step();
            checks++;
            if (misaligned_o !== 1'b0 || mem_v_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL misaligned_end_%0d: mis=%b mem_v=%b ready=%b, want 0 0 1",
                         i, misaligned_o, mem_v_o, ready_o);
            end
        end
    endtask

    task automatic test_nop_ops();
        logic [1:0] ops [2] = '{2'b00, 2'b11};
        for (int i = 0; i < 2; i++) begin
            drive_access(ops[i], 2'd3, 1'b0, 32'h0000_0001, 32'h0, 5'd1);
            step();
            idle_inputs();
            checks++;
            if (mem_v_o !== 1'b0 || misaligned_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL nop_%0d: mem_v=%b mis=%b ready=%b, want 0 0 1",
                         i, mem_v_o, misaligned_o, ready_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_access(2'b01, 2'd2, 1'b0, 32'h0000_2000, 32'h0, 5'd5);
        step();
        idle_inputs();
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || mem_v_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_idle: ready=%b mem_v=%b addr=%h, want 1 0 0",
                     ready_o, mem_v_o, mem_addr_o);
        end
        mem_v_i = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        step();
        mem_v_i = 1'b0;
        checks++;
        if (wb_v_o !== 1'b0 || ready_o !== 1'b1 || wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_late: wb_v=%b ready=%b wb_data=%h, want 0 1 0",
                     wb_v_o, ready_o, wb_data_o);
        end
    endtask

    task automatic test_back_to_back();
        drive_access(2'b01, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 5'd3);
        step();
        idle_inputs();
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        mem_v_i = 1'b1;
        mem_rdata_i = 32'h1122_3344;
        step();
        mem_v_i = 1'b0;
        checks++;
        if (wb_v_o !== 1'b1 || ready_o !== 1'b1 || wb_rd_o !== 5'd3 || wb_data_o !== 32'h1122_3344) begin
            errors++;
            $display("FAIL b2b_wb: wb_v=%b ready=%b rd=%0d data=%h, want 1 1 3 11223344",
                     wb_v_o, ready_o, wb_rd_o, wb_data_o);
        end
        drive_access(2'b10, 2'd2, 1'b0, 32'h0000_5008, 32'h0BAD_F00D, 5'd0);
        step();
        idle_inputs();
        checks++;
        if (mem_v_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h0000_5008 ||
            mem_mask_o !== 4'hF || mem_wdata_o !== 32'h0BAD_F00D || wb_v_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sw: v=%b we=%b addr=%h mask=%h wdata=%h wb_v=%b, want 1 1 00005008 f 0badf00d 0",
                     mem_v_o, mem_we_o, mem_addr_o, mem_mask_o, mem_wdata_o, wb_v_o);
        end
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || mem_v_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: ready=%b mem_v=%b, want 1 0", ready_o, mem_v_o);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        mem_ready_i = 1'b0;
        mem_v_i = 1'b0;
        mem_rdata_i = '0;
        test_reset();
        test_store_word();
        test_store_byte_stall();
        test_loads();
        test_misaligned();
        test_nop_ops();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the vanilla core, directly downstream of the execute-stage ALU. Takes the ALU's effective-address sum (base + sign-extended I/S immediate) together with the store operand and access type. Issues one word-aligned request at a time to the tile's data memory/network port, using byte-mask and lane replication. For loads, it aligns and sign- or zero-extends the response and presents it for register writeback. Misaligned accesses are flagged without issuing a request.

## Interface
Parameters:
- data_width_p, 32, data/address width; only 32 is supported.
- reg_addr_width_p, 5, destination register index width.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  access valid from execute stage.
- ready_o  out  1  unit can accept an access this cycle.
- op_i  in  2  access kind: 2'b01 load, 2'b10 store; 00/11 are accepted and dropped with no effect.
- size_i  in  2  0 byte, 1 half, 2 word, 3 illegal.
- unsigned_i  in  1  load zero-extends (LBU/LHU) when 1.
- addr_i  in  32  effective address (ALU sum).
- store_data_i  in  32  rs2 value.
- rd_i  in  5  load destination register.
- mem_v_o  out  1  memory request valid.
- mem_ready_i  in  1  memory accepts request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  32  {addr[31:2],2'b00}.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_mask_o  out  4  byte enables.
- mem_v_i  in  1  load response valid.
- mem_rdata_i  in  32  load response word.
- wb_v_o  out  1  writeback valid, one-cycle pulse.
- wb_rd_o  out  5  writeback register.
- wb_data_o  out  32  aligned and extended load data.
- misaligned_o  out  1  one-cycle pulse, misaligned or illegal-size access.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - ready_o=1.
  - On v_i, all fields are latched.
  - op 00/11: no effect; stay in IDLE.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0, or size 3): misaligned_o=1 next cycle, no request, stay in IDLE.
  - Otherwise go to REQ.
- **REQ**
  - ready_o=0; mem_v_o=1.
  - All mem_* outputs are registered and held stable until mem_ready_i.
  - On mem_v_o&mem_ready_i: a store goes to IDLE; a load goes to WAIT.
- **WAIT**
  - ready_o=0.
  - On mem_v_i, the extracted data is registered, wb_v_o=1 next cycle (if rd≠0), and the FSM goes to IDLE.
- mem_v_i is ignored outside WAIT. Only one access is outstanding at a time.
- **Store mask by size**
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'hF.
- **Store data**
  - Byte: data[7:0] replicated 4×.
  - Half: data[15:0] replicated 2×.
  - Word: unchanged.
- For loads, mem_mask_o uses the same mask rules and mem_wdata_o=0.
- **Load extraction**
  - Shift the response: s = mem_rdata_i >> (8*addr[1:0]).
  - Byte: {{24{s[7]&~unsigned}},s[7:0]}.
  - Half: {{16{s[15]&~unsigned}},s[15:0]}.
  - Word: mem_rdata_i.
- Loads to rd=0 complete the memory transaction but never assert wb_v_o.

## Timing
- Reset values: state IDLE; ready_o=1 from the first cycle after reset; mem_v_o, wb_v_o and misaligned_o =0; mem_addr_o, mem_wdata_o, mem_mask_o, wb_rd_o and wb_data_o =0.
- Reset mid-operation: go to IDLE and discard any in-flight request. A late mem_v_i is ignored.
- Accept at cycle 0 → mem_v_o at cycle 1.
- Store: if mem_ready_i at cycle 1, ready_o=1 at cycle 2. Each stalled cycle adds 1.
- Load: response at cycle k (k≥2) → wb_v_o and ready_o both at cycle k+1. A new access may be accepted in that same cycle.
- A mem_v_i arriving in the same cycle as the request is accepted is ignored; the response arrives no earlier than the next cycle.
- misaligned_o fires at cycle 1, with ready_o held at 1 throughout.
- wb_v_o has no backpressure: it is a single-cycle pulse.

## Test plan
- SW, addr 0x1004, data 0xDEADBEEF, mem_ready_i=1 → cycle 1: mem_addr_o=0x1004, mask 4'hF, wdata 0xDEADBEEF, we=1; ready_o=1 at cycle 2.
- SB, addr 0x1003, data 0x000000A5, mem_ready_i low 3 cycles → mask 4'b1000, wdata 0xA5A5A5A5 held stable across the stall; exactly one handshake.
- LB, addr 0x2002, rd=7, rdata 0x12F43456 at cycle 3 → wb_v_o at cycle 4, wb_rd_o=7, wb_data_o=0xFFFFFFF4. The same access as LBU gives 0x000000F4.
- LH, addr 0x2001 → misaligned_o pulse at cycle 1, no mem_v_o. LW to rd=0 completes the transaction with no wb_v_o.
- Load in WAIT, reset_i asserted for 1 cycle, then mem_v_i → no wb_v_o, state IDLE, ready_o=1.
- Back-to-back: a new SW accepted in the same cycle as a prior LW's wb_v_o → mem_v_o on the next cycle with correct fields.
